exc_sched: RTL and testbench

Exception and interrupt scheduler sitting between the pipeline and coprocessor 0. It arbitrates among eret, syscall/break and hardware-interrupt requests, stalls and drains the pipeline, issues exactly one cop0 operation per event, and returns the cop0-supplied target as a one-cycle PC redirect with flush. It also optionally hosts the COUNT/COMPARE timer that raises hardware interrupt line 5.

---
 rtl/exc_sched_pkg.sv | 43 ++++
 rtl/exc_timer.sv | 45 ++++
 rtl/exc_sched.sv | 162 ++++++++++++++++
 tb/tb_exc_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_sched_pkg.sv
// Shared encodings for the exception/interrupt scheduler.
// Holds cop0 op codes, STATUS bit indices, FSM and event-kind enums.
package exc_sched_pkg;

   localparam logic [3:0] COP_OP_NOP = 4'h0;
   localparam logic [3:0] COP_OP_RET = 4'h1;
   localparam logic [3:0] COP_OP_SYS = 4'h2;
   localparam logic [3:0] COP_OP_BRK = 4'h3;
   localparam logic [3:0] COP_OP_INT = 4'h4;

   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_ERL   = 2;
   localparam int ST_IM_LO = 10;
   localparam int ST_IM_HI = 15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_ISSUE = 2'd2,
      S_REDIR = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_RET = 2'd0,
      K_SYS = 2'd1,
      K_BRK = 2'd2,
      K_INT = 2'd3
   } kind_t;

   function automatic logic [3:0] kind_op(input kind_t k);
      logic [3:0] op;
      op = COP_OP_NOP;
      unique case (k)
         K_RET: op = COP_OP_RET;
         K_SYS: op = COP_OP_SYS;
         K_BRK: op = COP_OP_BRK;
         K_INT: op = COP_OP_INT;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/exc_timer.sv
// COUNT/COMPARE timer; raises a sticky match line when COUNT hits
// a non-zero COMPARE. A COMPARE write clears the line.
module exc_timer
   import exc_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        compare_wr,
   input  logic [31:0] compare_wdata,
   output logic [31:0] count,
   output logic        timer_irq
);

   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        irq_q, irq_d;

   // next COUNT, COMPARE and match line
   always_comb begin
      count_d = count_q + 32'd1;
      cmp_d   = compare_wr ? compare_wdata : cmp_q;
      irq_d   = irq_q;
      if (compare_wr)
         irq_d = 1'b0;
      else if ((count_q == cmp_q) && (cmp_q != 32'd0))
         irq_d = 1'b1;
   end

   // timer state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= 32'd0;
         cmp_q   <= 32'd0;
         irq_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         irq_q   <= irq_d;
      end
   end

   assign count     = count_q;
   assign timer_irq = irq_q;

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: arbitrate, drain, issue cop0 op, redirect.
// Optional COUNT/COMPARE timer enabled with macro TIMER_INT_EN.
module exc_sched
   import exc_sched_pkg::*;
#(
   parameter int TIMER_LINE = 5
) (
   input  logic        clk,
   input  logic        rst,
`ifdef TIMER_INT_EN
   input  logic        compare_wr,
   input  logic [31:0] compare_wdata,
   output logic [31:0] count,
`endif
   input  logic [5:0]  hard_int,
   input  logic        exc_req,
   input  logic        exc_is_brk,
   input  logic [31:0] exc_pc,
   input  logic        eret_req,
   input  logic        pipe_idle,
   input  logic [31:0] status,
   input  logic [31:0] cop_data,
   output logic [3:0]  cop_op,
   output logic [31:0] cop_next_pc,
   output logic [5:0]  cop_hard_int,
   output logic        exc_ack,
   output logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush
);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [31:0] pc_q, pc_d;
   logic [5:0]  plat_q, plat_d;
   logic [5:0]  hint_q, hint_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] npc_q, npc_d;
   logic [5:0]  chi_q, chi_d;
   logic        ack_q, ack_d;
   logic        stall_q, stall_d;
   logic        redir_q, redir_d;
   logic [31:0] rpc_q, rpc_d;

   logic        timer_irq;
   logic [5:0]  pend;
   logic        int_ok;
   logic        unused_status;

`ifdef TIMER_INT_EN
   exc_timer u_timer (
      .clk           (clk),
      .rst           (rst),
      .compare_wr    (compare_wr),
      .compare_wdata (compare_wdata),
      .count         (count),
      .timer_irq     (timer_irq)
   );
`else
   assign timer_irq = 1'b0;
`endif

   assign pend = hint_q | (6'(timer_irq) << TIMER_LINE);

   assign int_ok = status[ST_IE] & ~status[ST_EXL] & ~status[ST_ERL]
                 & (|(status[ST_IM_HI:ST_IM_LO] & pend));

   assign unused_status = ^{status[31:16], status[9:3]};

   // arbitration, sequencing and next-cycle output values
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      pc_d    = pc_q;
      plat_d  = plat_q;
      hint_d  = hard_int;
      op_d    = COP_OP_NOP;
      npc_d   = 32'd0;
      chi_d   = 6'd0;
      ack_d   = 1'b0;
      stall_d = 1'b0;
      redir_d = 1'b0;
      rpc_d   = 32'd0;
      unique case (state_q)
         S_IDLE: begin
            if (eret_req || exc_req || int_ok) begin
               state_d = S_DRAIN;
               stall_d = 1'b1;
               pc_d    = exc_pc;
               plat_d  = pend;
               if (eret_req)
                  kind_d = K_RET;
               else if (exc_req)
                  kind_d = exc_is_brk ? K_BRK : K_SYS;
               else
                  kind_d = K_INT;
            end
         end
         S_DRAIN: begin
            stall_d = 1'b1;
            if (pipe_idle) begin
               state_d = S_ISSUE;
               op_d    = kind_op(kind_q);
               npc_d   = pc_q;
               chi_d   = plat_q;
               ack_d   = (kind_q != K_INT);
            end
         end
         S_ISSUE: begin
            state_d = S_REDIR;
            stall_d = 1'b1;
            redir_d = 1'b1;
            rpc_d   = cop_data;
         end
         S_REDIR: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, latched event and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         kind_q  <= K_RET;
         pc_q    <= 32'd0;
         plat_q  <= 6'd0;
         hint_q  <= 6'd0;
         op_q    <= COP_OP_NOP;
         npc_q   <= 32'd0;
         chi_q   <= 6'd0;
         ack_q   <= 1'b0;
         stall_q <= 1'b0;
         redir_q <= 1'b0;
         rpc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         pc_q    <= pc_d;
         plat_q  <= plat_d;
         hint_q  <= hint_d;
         op_q    <= op_d;
         npc_q   <= npc_d;
         chi_q   <= chi_d;
         ack_q   <= ack_d;
         stall_q <= stall_d;
         redir_q <= redir_d;
         rpc_q   <= rpc_d;
      end
   end

   assign cop_op         = op_q;
   assign cop_next_pc    = npc_q;
   assign cop_hard_int   = chi_q;
   assign exc_ack        = ack_q;
   assign stall          = stall_q;
   assign redirect_valid = redir_q;
   assign redirect_pc    = rpc_q;
   assign flush          = redir_q;

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched; timer scenario built with TIMER_INT_EN.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_exc_sched;
   import exc_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  hard_int;
   logic        exc_req;
   logic        exc_is_brk;
   logic [31:0] exc_pc;
   logic        eret_req;
   logic        pipe_idle;
   logic [31:0] status;
   logic [31:0] cop_data;
   logic [3:0]  cop_op;
   logic [31:0] cop_next_pc;
   logic [5:0]  cop_hard_int;
   logic        exc_ack;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
`ifdef TIMER_INT_EN
   logic        compare_wr;
   logic [31:0] compare_wdata;
   logic [31:0] count;
`endif

   int checks = 0;
   int errors = 0;

   exc_sched #(.TIMER_LINE(5)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef TIMER_INT_EN
      .compare_wr     (compare_wr),
      .compare_wdata  (compare_wdata),
      .count          (count),
`endif
      .hard_int       (hard_int),
      .exc_req        (exc_req),
      .exc_is_brk     (exc_is_brk),
      .exc_pc         (exc_pc),
      .eret_req       (eret_req),
      .pipe_idle      (pipe_idle),
      .status         (status),
      .cop_data       (cop_data),
      .cop_op         (cop_op),
      .cop_next_pc    (cop_next_pc),
      .cop_hard_int   (cop_hard_int),
      .exc_ack        (exc_ack),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      hard_int = '0; exc_req = 0; exc_is_brk = 0; exc_pc = '0;
      eret_req = 0; pipe_idle = 1; status = '0; cop_data = '0;
`ifdef TIMER_INT_EN
      compare_wr = 0; compare_wdata = '0;
`endif
      tick();
      checks++;
      if ({cop_op, cop_next_pc, cop_hard_int} !== {COP_OP_NOP, 32'd0, 6'd0}) begin
         errors++;
         $display("FAIL reset_cop op=%h pc=%h hi=%h want NOP/0/0", cop_op, cop_next_pc, cop_hard_int);
      end
      checks++;
      if ({exc_ack, stall, redirect_valid, flush, redirect_pc} !== 36'd0) begin
         errors++;
         $display("FAIL reset_ctl ack=%b st=%b rv=%b fl=%b rpc=%h want 0", exc_ack, stall, redirect_valid, flush, redirect_pc);
      end
`ifdef TIMER_INT_EN
      checks++;
      if (count !== 32'd0) begin
         errors++;
         $display("FAIL reset_count got=%h want 0", count);
      end
`endif
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_syscall();
      exc_req = 1; exc_is_brk = 0; exc_pc = 32'h0040_0010;
      pipe_idle = 1; cop_data = 32'h8000_0180;
      tick();
      checks++;
      if ({stall, cop_op, exc_ack} !== {1'b1, COP_OP_NOP, 1'b0}) begin
         errors++;
         $display("FAIL sys_drain st=%b op=%h ack=%b want 1/NOP/0", stall, cop_op, exc_ack);
      end
      tick();
      checks++;
      if ({stall, cop_op, exc_ack, cop_next_pc} !== {1'b1, COP_OP_SYS, 1'b1, 32'h0040_0010}) begin
         errors++;
         $display("FAIL sys_issue st=%b op=%h ack=%b pc=%h want 1/SYS/1/00400010", stall, cop_op, exc_ack, cop_next_pc);
      end
      exc_req = 0;
      tick();
      checks++;
      if ({stall, redirect_valid, flush, exc_ack, cop_op, redirect_pc} !== {4'b1110, COP_OP_NOP, 32'h8000_0180}) begin
         errors++;
         $display("FAIL sys_redir st=%b rv=%b fl=%b ack=%b op=%h rpc=%h want 1110/NOP/80000180", stall, redirect_valid, flush, exc_ack, cop_op, redirect_pc);
      end
      tick();
      checks++;
      if ({stall, redirect_valid, flush} !== 3'b000) begin
         errors++;
         $display("FAIL sys_done st=%b rv=%b fl=%b want 000", stall, redirect_valid, flush);
      end
   endtask

   task automatic test_back_to_back();
      eret_req = 1; exc_req = 1; exc_is_brk = 1; exc_pc = 32'h0040_0030;
      cop_data = 32'h0040_0020;
      tick();
      tick();
      checks++;
      if ({cop_op, exc_ack} !== {COP_OP_RET, 1'b1}) begin
         errors++;
         $display("FAIL b2b_ret op=%h ack=%b want RET/1", cop_op, exc_ack);
      end
      eret_req = 0;
      tick();
      checks++;
      if ({redirect_valid, exc_ack, redirect_pc} !== {2'b10, 32'h0040_0020}) begin
         errors++;
         $display("FAIL b2b_ret_redir rv=%b ack=%b rpc=%h want 1/0/00400020", redirect_valid, exc_ack, redirect_pc);
      end
      cop_data = 32'h8000_0180;
      tick();
      checks++;
      if ({stall, exc_ack} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_gap st=%b ack=%b want 00", stall, exc_ack);
      end
      tick();
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept st=%b want 1", stall);
      end
      tick();
      checks++;
      if ({cop_op, exc_ack, cop_next_pc} !== {COP_OP_BRK, 1'b1, 32'h0040_0030}) begin
         errors++;
         $display("FAIL b2b_brk op=%h ack=%b pc=%h want BRK/1/00400030", cop_op, exc_ack, cop_next_pc);
      end
      exc_req = 0; exc_is_brk = 0;
      tick();
      checks++;
      if ({redirect_valid, flush, redirect_pc} !== {2'b11, 32'h8000_0180}) begin
         errors++;
         $display("FAIL b2b_brk_redir rv=%b fl=%b rpc=%h want 11/80000180", redirect_valid, flush, redirect_pc);
      end
      tick();
      tick();
      checks++;
      if ({stall, cop_op} !== {1'b0, COP_OP_NOP}) begin
         errors++;
         $display("FAIL b2b_quiet st=%b op=%h want 0/NOP", stall, cop_op);
      end
   endtask

   task automatic test_interrupt();
      status = 32'h0000_1001; hard_int = 6'h04; exc_pc = 32'h0040_0040;
      cop_data = 32'h8000_0200;
      tick();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL int_sync st=%b want 0", stall);
      end
      tick();
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL int_drain st=%b want 1", stall);
      end
      hard_int = 6'h00;
      tick();
      checks++;
      if ({cop_op, cop_hard_int, exc_ack, cop_next_pc} !== {COP_OP_INT, 6'h04, 1'b0, 32'h0040_0040}) begin
         errors++;
         $display("FAIL int_issue op=%h hi=%h ack=%b pc=%h want INT/04/0/00400040", cop_op, cop_hard_int, exc_ack, cop_next_pc);
      end
      tick();
      checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0200}) begin
         errors++;
         $display("FAIL int_redir rv=%b rpc=%h want 1/80000200", redirect_valid, redirect_pc);
      end
      tick();
      status = 32'h0000_1003; hard_int = 6'h04;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({stall, cop_op} !== {1'b0, COP_OP_NOP}) begin
            errors++;
            $display("FAIL int_exl_masked cyc=%0d st=%b op=%h want 0/NOP", i, stall, cop_op);
         end
      end
      hard_int = 6'h00; status = 32'h0;
      tick();
      tick();
   endtask

   task automatic test_drain_wait();
      exc_req = 1; exc_is_brk = 0; exc_pc = 32'h0040_0050;
      pipe_idle = 0; cop_data = 32'h8000_0180;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({stall, cop_op} !== {1'b1, COP_OP_NOP}) begin
            errors++;
            $display("FAIL drain_wait cyc=%0d st=%b op=%h want 1/NOP", i, stall, cop_op);
         end
         tick();
      end
      pipe_idle = 1;
      checks++;
      if ({stall, cop_op} !== {1'b1, COP_OP_NOP}) begin
         errors++;
         $display("FAIL drain_last st=%b op=%h want 1/NOP", stall, cop_op);
      end
      tick();
      checks++;
      if ({stall, cop_op, exc_ack} !== {1'b1, COP_OP_SYS, 1'b1}) begin
         errors++;
         $display("FAIL drain_issue st=%b op=%h ack=%b want 1/SYS/1", stall, cop_op, exc_ack);
      end
      exc_req = 0;
      tick();
      tick();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL drain_done st=%b want 0", stall);
      end
   endtask

   task automatic test_reset_mid();
      exc_req = 1; exc_is_brk = 0; exc_pc = 32'h0040_0060; pipe_idle = 0;
      tick();
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_drain st=%b want 1", stall);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall, cop_op, exc_ack, redirect_valid, flush} !== {1'b0, COP_OP_NOP, 3'b000}) begin
         errors++;
         $display("FAIL rstmid_async st=%b op=%h ack=%b rv=%b fl=%b want 0/NOP/000", stall, cop_op, exc_ack, redirect_valid, flush);
      end
      exc_req = 0; pipe_idle = 1;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({stall, cop_op, redirect_valid} !== {1'b0, COP_OP_NOP, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_after cyc=%0d st=%b op=%h rv=%b want 0/NOP/0", i, stall, cop_op, redirect_valid);
         end
      end
   endtask

`ifdef TIMER_INT_EN
   task automatic test_timer();
      status = 32'h0000_8001; cop_data = 32'h8000_0180;
      rst = 1'b0;
      tick();
      rst = 1'b1; compare_wr = 1; compare_wdata = 32'd10;
      tick();
      compare_wr = 0;
      repeat (9) tick();
      checks++;
      if ({count, stall} !== {32'd10, 1'b0}) begin
         errors++;
         $display("FAIL timer_count cnt=%0d st=%b want 10/0", count, stall);
      end
      tick();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL timer_pre st=%b want 0", stall);
      end
      tick();
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL timer_drain st=%b want 1", stall);
      end
      tick();
      checks++;
      if ({cop_op, cop_hard_int, exc_ack} !== {COP_OP_INT, 6'h20, 1'b0}) begin
         errors++;
         $display("FAIL timer_issue op=%h hi=%h ack=%b want INT/20/0", cop_op, cop_hard_int, exc_ack);
      end
      compare_wr = 1; compare_wdata = 32'd0;
      tick();
      compare_wr = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({stall, cop_op} !== {1'b0, COP_OP_NOP}) begin
            errors++;
            $display("FAIL timer_cleared cyc=%0d st=%b op=%h want 0/NOP", i, stall, cop_op);
         end
      end
      status = 32'h0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_syscall();
      test_back_to_back();
      test_interrupt();
      test_drain_wait();
      test_reset_mid();
`ifdef TIMER_INT_EN
      test_timer();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
